// File: rtl/lsu_mem_req_pkg.sv
// Shared types for the memory-access stage: FSM states, access-size codes and
// the load-lane shift helper.
package lsu_mem_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } lsu_state_e;

    // funct3[1:0] access size for both loads and stores; funct3[2] is the unsigned flag
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [31:0] lane_shift(input logic [31:0] word, input logic [1:0] off);
        return word >> {off, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_mem_req_align.sv
// Store alignment: byte strobes, lane-replicated write data and misalignment
// detection from the low address bits and access size.
module lsu_mem_req_align
    import lsu_mem_req_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    // Decode strobes and replicate data into every lane the access may hit
    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                misalign  = 1'b0;
            end
            SZ_H: begin
                wstrb     = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            SZ_W: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
                misalign  = |addr_lo;
            end
            default: begin
                wstrb     = 4'b0000;
                wdata_rep = wdata;
                misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Memory-access stage of the RV32I pipeline: issues one word-aligned bus request
// per load/store, waits for the response (with timeout) and hands raw data to writeback.
module lsu_mem_req
    import lsu_mem_req_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_mem_ren,
    input  logic        in_mem_wen,
    input  logic [31:0] in_ex_result,
    input  logic [4:0]  in_rd,
    input  logic        in_R_wen,
    input  logic [31:0] in_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_wstrb,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_mem_rdata,
    output logic [2:0]  out_funct3,
    output logic        out_mem_ren,
    output logic [31:0] out_ex_result,
    output logic [4:0]  out_rd,
    output logic        out_R_wen,
    output logic [31:0] out_pc,
    output logic        misalign_err,
    output logic        bus_err
);

    // Last RESP cycle before timeout fires; counter holds 0 on the first RESP cycle
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic             TO_EN   = (TIMEOUT_CYC != 0);

    lsu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_valid_r;
    logic             req_we_r;
    logic [31:0]      req_addr_r;
    logic [3:0]       req_wstrb_r;
    logic [31:0]      req_wdata_r;
    logic [1:0]       off_r;
    logic             out_valid_r;
    logic [31:0]      rdata_r;
    logic [2:0]       f3_r;
    logic             ren_r;
    logic [31:0]      ex_r;
    logic [4:0]       rd_r;
    logic             rwen_r;
    logic [31:0]      pc_r;
    logic             mis_r;
    logic             berr_r;

    logic [3:0]       wstrb_s;
    logic [31:0]      wdata_rep_s;
    logic             misalign_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             mem_op_s;
    logic             bad_s;
    logic             timeout_s;

    lsu_mem_req_align u_align (
        .addr_lo   (in_addr[1:0]),
        .size      (in_funct3[1:0]),
        .wdata     (in_wdata),
        .wstrb     (wstrb_s),
        .wdata_rep (wdata_rep_s),
        .misalign  (misalign_s)
    );

    // in_ready is gated by reset_n so nothing is offered while reset is held
    assign in_ready_s = reset_n & ((state_r == ST_IDLE) | ((state_r == ST_HOLD) & out_ready));
    assign accept_s   = in_valid & in_ready_s;
    assign mem_op_s   = in_mem_ren | in_mem_wen;
    assign bad_s      = mem_op_s & misalign_s;
    assign timeout_s  = TO_EN & (cnt_r == TO_LAST);

    // Transaction FSM and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_valid_r <= 1'b0;
            req_we_r    <= 1'b0;
            req_addr_r  <= 32'h0000_0000;
            req_wstrb_r <= 4'b0000;
            req_wdata_r <= 32'h0000_0000;
            off_r       <= 2'b00;
            out_valid_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            f3_r        <= 3'b000;
            ren_r       <= 1'b0;
            ex_r        <= 32'h0000_0000;
            rd_r        <= 5'd0;
            rwen_r      <= 1'b0;
            pc_r        <= 32'h0000_0000;
            mis_r       <= 1'b0;
            berr_r      <= 1'b0;
        end else if (accept_s) begin
            // New op from IDLE, or back-to-back from HOLD as writeback drains the old one
            f3_r        <= in_funct3;
            ren_r       <= in_mem_ren;
            ex_r        <= in_ex_result;
            rd_r        <= in_rd;
            pc_r        <= in_pc;
            rwen_r      <= in_R_wen & ~bad_s;
            mis_r       <= bad_s;
            berr_r      <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            off_r       <= in_addr[1:0];
            cnt_r       <= {CNT_W{1'b0}};
            req_addr_r  <= {in_addr[31:2], 2'b00};
            req_we_r    <= in_mem_wen;
            req_wstrb_r <= in_mem_wen ? wstrb_s : 4'b0000;
            req_wdata_r <= wdata_rep_s;
            if (mem_op_s & ~misalign_s) begin
                state_r     <= ST_REQ;
                req_valid_r <= 1'b1;
                out_valid_r <= 1'b0;
            end else begin
                state_r     <= ST_HOLD;
                req_valid_r <= 1'b0;
                out_valid_r <= 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_r     <= ST_RESP;
                        req_valid_r <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                    end
                end
                ST_RESP: begin
                    // A response in the timeout cycle still completes normally
                    if (mem_resp_valid) begin
                        rdata_r     <= lane_shift(mem_resp_rdata, off_r);
                        berr_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else if (timeout_s) begin
                        rdata_r     <= 32'h0000_0000;
                        berr_r      <= 1'b1;
                        rwen_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_valid_r <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_s;
    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_we    = req_we_r;
    assign mem_req_wstrb = req_wstrb_r;
    assign mem_req_wdata = req_wdata_r;
    assign out_valid     = out_valid_r;
    assign out_mem_rdata = rdata_r;
    assign out_funct3    = f3_r;
    assign out_mem_ren   = ren_r;
    assign out_ex_result = ex_r;
    assign out_rd        = rd_r;
    assign out_R_wen     = rwen_r;
    assign out_pc        = pc_r;
    assign misalign_err  = mis_r;
    assign bus_err       = berr_r;

endmodule
